// File: rtl/regfile_param_if.sv
// Operand-fetch register file bus: read/write addresses, write data, clear
// request, and the registered read data and busy status coming back.
interface regfile_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [ADDR_W-1:0] RW;
  logic [WIDTH-1:0]  BusW;
  logic              RegWr;
  logic              Clr;
  logic              Busy;
  logic [WIDTH-1:0]  BusA;
  logic [WIDTH-1:0]  BusB;

  modport master (output RA, RB, RW, BusW, RegWr, Clr, input Busy, BusA, BusB);
  modport slave  (input RA, RB, RW, BusW, RegWr, Clr, output Busy, BusA, BusB);
endinterface

// File: rtl/regfile_param.sv
// Parameterised register file: one write port, two registered read ports,
// optional write-to-read bypass, optional hardwired r0 and a sequenced clear.
module regfile_param_entry #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n)  q <= '0;
    else if (we) q <= d;
endmodule

module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                       state;
  logic [ADDR_W-1:0]            cnt;
  logic                         we;
  logic [ADDR_W-1:0]            wa;
  logic [WIDTH-1:0]             wd;
  logic [WIDTH-1:0]             rd_a, rd_b;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;

  // One effective write per cycle: the clear engine owns the port while
  // active, and writes aimed at a hardwired r0 are dropped (never bypassed).
  always_comb begin
    we = 1'b0;
    wa = bus.RW;
    wd = bus.BusW;
    if (state == CLEAR) begin
      we = 1'b1;
      wa = cnt;
      wd = '0;
    end else if (bus.RegWr) begin
      we = 1'b1;
    end
    if (ZERO_REG != 0 && wa == '0) we = 1'b0;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    regfile_param_entry #(.WIDTH(WIDTH)) u_ent (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .we    (we && wa == ADDR_W'(i)),
      .d     (wd),
      .q     (mem[i])
    );
  end

  function automatic logic [WIDTH-1:0] rd_val(
    input logic [ADDR_W-1:0]           a,
    input logic                        w_en,
    input logic [ADDR_W-1:0]           w_a,
    input logic [WIDTH-1:0]            w_d,
    input logic [DEPTH-1:0][WIDTH-1:0] arr
  );
    if (ZERO_REG != 0 && a == '0)           return '0;
    else if (BYPASS != 0 && w_en && w_a == a) return w_d;
    else                                      return arr[a];
  endfunction

  always_comb begin
    rd_a = rd_val(bus.RA, we, wa, wd, mem);
    rd_b = rd_val(bus.RB, we, wa, wd, mem);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.Busy <= 1'b0;
      bus.BusA <= '0;
      bus.BusB <= '0;
    end else begin
      bus.BusA <= rd_a;
      bus.BusB <= rd_b;
      case (state)
        IDLE: if (bus.Clr) begin
          state    <= CLEAR;
          cnt      <= '0;
          bus.Busy <= 1'b1;
        end
        CLEAR: if (cnt == ADDR_W'(DEPTH-1)) begin
          state    <= IDLE;
          cnt      <= '0;
          bus.Busy <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param across four parameter sets: default,
// no bypass, hardwired r0, and a narrow 16x8 file for the mid-clear reset.
module tb_regfile_param;
  logic clk = 1'b0;
  logic rst0, rst1, rst2, rst3;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  regfile_param_if #(.WIDTH(32), .ADDR_W(4)) i0 ();
  regfile_param_if #(.WIDTH(32), .ADDR_W(4)) i1 ();
  regfile_param_if #(.WIDTH(32), .ADDR_W(4)) i2 ();
  regfile_param_if #(.WIDTH(16), .ADDR_W(3)) i3 ();

  regfile_param #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u0 (.Clk(clk), .Rst_n(rst0), .bus(i0));
  regfile_param #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) u1 (.Clk(clk), .Rst_n(rst1), .bus(i1));
  regfile_param #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u2 (.Clk(clk), .Rst_n(rst2), .bus(i2));
  regfile_param #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u3 (.Clk(clk), .Rst_n(rst3), .bus(i3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (i0.BusA !== 32'h0 || i0.BusB !== 32'h0) $display("FAIL reset_bus got %h/%h want 0/0", i0.BusA, i0.BusB); else passes++;
    checks++; if (i0.Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", i0.Busy); else passes++;
    i0.RegWr = 1; i0.RW = 5; i0.BusW = 32'hDEADBEEF; i0.RA = 0;
    tick();
    i0.RegWr = 0; i0.RA = 5;
    tick();
    checks++; if (i0.BusA !== 32'hDEADBEEF) $display("FAIL readback_r5 got %h want deadbeef", i0.BusA); else passes++;
    #2 rst0 = 0;
    #1;
    checks++; if (i0.BusA !== 32'h0 || i0.Busy !== 1'b0) $display("FAIL async_reset got %h busy %b want 0 busy 0", i0.BusA, i0.Busy); else passes++;
    @(negedge clk) rst0 = 1;
    tick();
    checks++; if (i0.BusA !== 32'h0) $display("FAIL r5_after_reset got %h want 0", i0.BusA); else passes++;
  endtask

  task automatic test_bypass();
    i0.RegWr = 1; i0.RW = 7; i0.BusW = 32'h12345678; i0.RA = 7; i0.RB = 7;
    tick();
    i0.RegWr = 0;
    checks++; if (i0.BusA !== 32'h12345678 || i0.BusB !== 32'h12345678) $display("FAIL bypass_same_edge got %h/%h want 12345678", i0.BusA, i0.BusB); else passes++;
    i1.RegWr = 1; i1.RW = 7; i1.BusW = 32'h12345678; i1.RA = 7; i1.RB = 7;
    tick();
    i1.RegWr = 0;
    checks++; if (i1.BusA !== 32'h0 || i1.BusB !== 32'h0) $display("FAIL nobypass_old got %h/%h want 0", i1.BusA, i1.BusB); else passes++;
    tick();
    checks++; if (i1.BusA !== 32'h12345678 || i1.BusB !== 32'h12345678) $display("FAIL nobypass_next got %h/%h want 12345678", i1.BusA, i1.BusB); else passes++;
  endtask

  task automatic test_zero_reg();
    i2.RegWr = 1; i2.RW = 0; i2.BusW = 32'hFFFFFFFF; i2.RA = 0; i2.RB = 1;
    tick();
    i2.RW = 1; i2.BusW = 32'h0000_0011;
    checks++; if (i2.BusA !== 32'h0) $display("FAIL zero_reg_same got %h want 0", i2.BusA); else passes++;
    tick();
    i2.RegWr = 0;
    checks++; if (i2.BusA !== 32'h0 || i2.BusB !== 32'h11) $display("FAIL zero_reg_later got %h/%h want 0/11", i2.BusA, i2.BusB); else passes++;
    tick();
    checks++; if (i2.BusA !== 32'h0) $display("FAIL zero_reg_hold got %h want 0", i2.BusA); else passes++;
    i0.RegWr = 1; i0.RW = 0; i0.BusW = 32'hFFFFFFFF; i0.RA = 0;
    tick();
    i0.RegWr = 0;
    checks++; if (i0.BusA !== 32'hFFFFFFFF) $display("FAIL r0_writable got %h want ffffffff", i0.BusA); else passes++;
    tick();
    checks++; if (i0.BusA !== 32'hFFFFFFFF) $display("FAIL r0_stored got %h want ffffffff", i0.BusA); else passes++;
  endtask

  task automatic test_clear();
    int busy_hi;
    for (int i = 0; i < 16; i++) begin
      i0.RegWr = 1; i0.RW = 4'(i); i0.BusW = 32'(i + 1);
      tick();
    end
    i0.RegWr = 0; i0.RA = 9; i0.RB = 10;
    tick();
    checks++; if (i0.BusA !== 32'd10 || i0.BusB !== 32'd11) $display("FAIL fill_readback got %0d/%0d want 10/11", i0.BusA, i0.BusB); else passes++;
    i0.Clr = 1; i0.RA = 15;
    tick();
    i0.Clr = 0;
    checks++; if (i0.Busy !== 1'b1) $display("FAIL clear_start_busy got %b want 1", i0.Busy); else passes++;
    busy_hi = 1;
    for (int k = 1; k <= 16; k++) begin
      i0.RegWr = (k == 1 || k == 16); i0.RW = 3; i0.BusW = 32'h55;
      tick();
      i0.RegWr = 0;
      if (i0.Busy === 1'b1) busy_hi++;
      if (k == 15) begin
        checks++; if (i0.BusA !== 32'd16) $display("FAIL r15_before_final got %0d want 16", i0.BusA); else passes++;
      end
      if (k == 16) begin
        checks++; if (i0.BusA !== 32'h0) $display("FAIL r15_final_bypass got %h want 0", i0.BusA); else passes++;
      end
    end
    checks++; if (busy_hi !== 16) $display("FAIL busy_length got %0d want 16", busy_hi); else passes++;
    for (int i = 0; i < 16; i++) begin
      i0.RA = 4'(i); i0.RB = 4'(15 - i);
      tick();
      checks++; if (i0.BusA !== 32'h0 || i0.BusB !== 32'h0) $display("FAIL cleared_r%0d got %h/%h want 0", i, i0.BusA, i0.BusB); else passes++;
    end
    i0.RegWr = 1; i0.RW = 3; i0.BusW = 32'h99;
    tick();
    i0.RegWr = 0; i0.RA = 3;
    tick();
    checks++; if (i0.BusA !== 32'h99) $display("FAIL write_after_clear got %h want 99", i0.BusA); else passes++;
  endtask

  task automatic test_clr_write();
    int guard;
    i0.RegWr = 1; i0.Clr = 1; i0.RW = 2; i0.BusW = 32'hAA; i0.RA = 2;
    tick();
    i0.RegWr = 0; i0.Clr = 0;
    checks++; if (i0.BusA !== 32'hAA) $display("FAIL clrwr_t0 got %h want aa", i0.BusA); else passes++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 2) begin
        checks++; if (i0.BusA !== 32'hAA) $display("FAIL clrwr_before_cnt2 got %h want aa", i0.BusA); else passes++;
      end
      if (k == 3) begin
        checks++; if (i0.BusA !== 32'h0) $display("FAIL clrwr_at_cnt2 got %h want 0", i0.BusA); else passes++;
      end
    end
    guard = 0;
    while (i0.Busy === 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    checks++; if (i0.Busy !== 1'b0) $display("FAIL clrwr_busy_timeout got %b want 0", i0.Busy); else passes++;
    tick();
    checks++; if (i0.BusA !== 32'h0) $display("FAIL clrwr_after got %h want 0", i0.BusA); else passes++;
  endtask

  task automatic test_reset_mid_clear();
    int busy_hi;
    for (int i = 0; i < 8; i++) begin
      i3.RegWr = 1; i3.RW = 3'(i); i3.BusW = 16'(16'h100 + i);
      tick();
    end
    i3.RegWr = 0; i3.RA = 7; i3.Clr = 1;
    tick();
    i3.Clr = 0;
    for (int k = 1; k <= 4; k++) tick();
    checks++; if (i3.BusA !== 16'h107 || i3.Busy !== 1'b1) $display("FAIL midclr_pre got %h busy %b want 0107 busy 1", i3.BusA, i3.Busy); else passes++;
    #2 rst3 = 0;
    #1;
    checks++; if (i3.Busy !== 1'b0 || i3.BusA !== 16'h0) $display("FAIL midclr_reset got busy %b %h want busy 0 0", i3.Busy, i3.BusA); else passes++;
    @(negedge clk) rst3 = 1;
    for (int i = 0; i < 8; i++) begin
      i3.RA = 3'(i); i3.RB = 3'(7 - i);
      tick();
      checks++; if (i3.BusA !== 16'h0 || i3.BusB !== 16'h0) $display("FAIL midclr_r%0d got %h/%h want 0", i, i3.BusA, i3.BusB); else passes++;
    end
    i3.Clr = 1;
    tick();
    i3.Clr = 0;
    busy_hi = (i3.Busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (i3.Busy === 1'b1) busy_hi++;
    end
    checks++; if (busy_hi !== 8) $display("FAIL fresh_clear_len got %0d want 8", busy_hi); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst0 = 0; rst1 = 0; rst2 = 0; rst3 = 0;
    i0.RA = 0; i0.RB = 0; i0.RW = 0; i0.BusW = 0; i0.RegWr = 0; i0.Clr = 0;
    i1.RA = 0; i1.RB = 0; i1.RW = 0; i1.BusW = 0; i1.RegWr = 0; i1.Clr = 0;
    i2.RA = 0; i2.RB = 0; i2.RW = 0; i2.BusW = 0; i2.RegWr = 0; i2.Clr = 0;
    i3.RA = 0; i3.RB = 0; i3.RW = 0; i3.BusW = 0; i3.RegWr = 0; i3.Clr = 0;
    repeat (2) @(negedge clk);
    rst0 = 1; rst1 = 1; rst2 = 1; rst3 = 1;
    tick();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_clr_write();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
